// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampled UART receiver that pushes checked bytes upstream with event strobes.
// Optional UART_RX_MAJORITY_VOTE_EN: 3-sample majority vote per bit instead of a single mid-bit sample.
module uart_rx_deserializer #(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    input  logic              baud_tick_i,
    input  logic              rx_en_i,
    input  logic              parity_en_i,
    input  logic              parity_odd_i,
    input  logic              stop2_i,
    input  logic              ufifo_full_i,
    output logic [DATA_W-1:0] data_o,
    output logic              push_o,
    output logic              rx_done_o,
    output logic              parity_err_o,
    output logic              bad_frame_o,
    output logic              overflow_o,
    output logic              busy_o
);
    localparam int CW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_W + 1);
    localparam int MID = OVERSAMPLE / 2 - 1;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int DEC = MID + 1;
`else
    localparam int DEC = MID;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2, BREAK} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_prev_q, rx_prev_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic [DATA_W-1:0]      sh_q, sh_d, data_q, data_d;
    logic                   pen_q, pen_d, podd_q, podd_d, stop2_q, stop2_d, pbad_q, pbad_d;
    logic                   push_q, push_d, done_q, done_d, perr_q, perr_d;
    logic                   bad_q, bad_d, ovf_q, ovf_d;
    logic                   rx_s, samp, bit_v, fin, good;
    logic [CW-1:0]          cnt_nx;

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign samp   = baud_tick_i && cnt_q == CW'(DEC);
    assign cnt_nx = (cnt_q == CW'(OVERSAMPLE - 1)) ? '0 : cnt_q + CW'(1);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] v_q, v_d;
    always_comb begin
        v_d = v_q;
        if (baud_tick_i && cnt_q == CW'(MID - 1)) v_d[0] = rx_s;
        if (baud_tick_i && cnt_q == CW'(MID)) v_d[1] = rx_s;
    end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) v_q <= 2'b11;
        else v_q <= v_d;
    assign bit_v = (v_q[0] & v_q[1]) | (v_q[0] & rx_s) | (v_q[1] & rx_s);
`else
    assign bit_v = rx_s;
`endif

    // Final stop-bit decision: second stop, or first stop when it ends the frame.
    assign fin  = rx_en_i && samp && (state_q == STOP2 || (state_q == STOP && !(bit_v && stop2_q)));
    assign good = !pbad_q && bit_v;

    always_comb begin
        state_d   = state_q;
        sync_d    = {sync_q[SYNC_STAGES-2:0], rx_i};
        rx_prev_d = rx_s;
        cnt_d     = (state_q == IDLE) ? '0 : baud_tick_i ? cnt_nx : cnt_q;
        bcnt_d    = bcnt_q;
        sh_d      = sh_q;
        pen_d     = pen_q;
        podd_d    = podd_q;
        stop2_d   = stop2_q;
        pbad_d    = pbad_q;
        push_d    = fin && good && !ufifo_full_i;
        done_d    = fin;
        perr_d    = fin && pbad_q;
        bad_d     = fin && !bit_v;
        ovf_d     = fin && good && ufifo_full_i;
        data_d    = push_d ? sh_q : data_q;
        if (fin && !bit_v) cnt_d = '0;
        case (state_q)
            IDLE: if (rx_en_i && rx_prev_q && !rx_s) begin
                state_d = START;
                pen_d   = parity_en_i;
                podd_d  = parity_odd_i;
                stop2_d = stop2_i;
                pbad_d  = 1'b0;
            end
            START: if (samp) begin
                state_d = bit_v ? IDLE : DATA;
                bcnt_d  = '0;
            end
            DATA: if (samp) begin
                sh_d   = {bit_v, sh_q[DATA_W-1:1]};
                bcnt_d = bcnt_q + BW'(1);
                if (bcnt_q == BW'(DATA_W - 1)) state_d = pen_q ? PARITY : STOP;
            end
            PARITY: if (samp) begin
                pbad_d  = ((^sh_q) ^ bit_v) != podd_q;
                state_d = STOP;
            end
            STOP: if (samp) state_d = !bit_v ? BREAK : stop2_q ? STOP2 : IDLE;
            STOP2: if (samp) state_d = bit_v ? IDLE : BREAK;
            BREAK: begin
                // Leave only after the line stays high across a whole tick interval.
                cnt_d = !rx_s ? '0 : baud_tick_i ? CW'(1) : cnt_q;
                if (rx_s && baud_tick_i && cnt_q != '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!rx_en_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            bcnt_q    <= '0;
            sh_q      <= '0;
            data_q    <= '0;
            pen_q     <= 1'b0;
            podd_q    <= 1'b0;
            stop2_q   <= 1'b0;
            pbad_q    <= 1'b0;
            push_q    <= 1'b0;
            done_q    <= 1'b0;
            perr_q    <= 1'b0;
            bad_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            rx_prev_q <= rx_prev_d;
            cnt_q     <= cnt_d;
            bcnt_q    <= bcnt_d;
            sh_q      <= sh_d;
            data_q    <= data_d;
            pen_q     <= pen_d;
            podd_q    <= podd_d;
            stop2_q   <= stop2_d;
            pbad_q    <= pbad_d;
            push_q    <= push_d;
            done_q    <= done_d;
            perr_q    <= perr_d;
            bad_q     <= bad_d;
            ovf_q     <= ovf_d;
        end
    end

    assign data_o       = data_q;
    assign push_o       = push_q;
    assign rx_done_o    = done_q;
    assign parity_err_o = perr_q;
    assign bad_frame_o  = bad_q;
    assign overflow_o   = ovf_q;
    assign busy_o       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed and randomized frames checked against a frame-level outcome model.
module tb_uart_rx_deserializer;
    localparam int OS  = 16;
    localparam int SPB = OS * 4;

    logic       clk = 0, rst = 1, rx = 1, baud_tick = 0, rx_en = 1;
    logic       parity_en = 0, parity_odd = 0, stop2 = 0, ufifo_full = 0;
    logic [7:0] data_o;
    logic       push_o, rx_done_o, parity_err_o, bad_frame_o, overflow_o, busy_o;
    logic       tick_held = 0;
    int         tcnt = 0;
    int         checks = 0, failures = 0;
    int         n_push = 0, n_done = 0, n_perr = 0, n_bad = 0, n_ovf = 0;
    logic [7:0] last_push = 0, exp_data = 0;

    uart_rx_deserializer #(.OVERSAMPLE(OS), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .rx_i(rx), .baud_tick_i(baud_tick), .rx_en_i(rx_en),
        .parity_en_i(parity_en), .parity_odd_i(parity_odd), .stop2_i(stop2),
        .ufifo_full_i(ufifo_full), .data_o(data_o), .push_o(push_o), .rx_done_o(rx_done_o),
        .parity_err_o(parity_err_o), .bad_frame_o(bad_frame_o), .overflow_o(overflow_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        tcnt = (tcnt + 1) % 4;
        baud_tick = tick_held ? 1'b1 : (tcnt == 0);
    end

    always @(negedge clk) begin
        if (push_o) begin n_push++; last_push = data_o; end
        if (rx_done_o) n_done++;
        if (parity_err_o) n_perr++;
        if (bad_frame_o) n_bad++;
        if (overflow_o) n_ovf++;
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int cpb, input bit g);
        rx = v;
        if (g) begin
            hold(cpb / 2 - 2); rx = ~v; hold(4); rx = v; hold(cpb - cpb / 2 - 2);
        end else hold(cpb);
    endtask

    task automatic run_frame(input string nm, input logic [7:0] d, input bit pen, input bit podd,
                             input bit s2, input bit pinj, input bit sbad, input bit full,
                             input int cpb, input bit g);
        int  p0, d0, e0, b0, o0;
        bit  xp, xe, xb, xo, pb;
        p0 = n_push; d0 = n_done; e0 = n_perr; b0 = n_bad; o0 = n_ovf;
        parity_en = pen; parity_odd = podd; stop2 = s2; ufifo_full = full;
        pb = (^d) ^ podd ^ pinj;
        xe = pen && pinj;
        xb = sbad;
        xp = !xe && !xb && !full;
        xo = !xe && !xb && full;
        drive_bit(1'b0, cpb, g);
        for (int i = 0; i < 8; i++) drive_bit(d[i], cpb, g);
        if (pen) drive_bit(pb, cpb, g);
        if (s2) drive_bit(1'b1, cpb, g);
        drive_bit(!sbad, cpb, g);
        rx = 1'b1;
        hold(2 * cpb);
        ufifo_full = 0;
        if (xp) exp_data = d;
        checks++; if (n_done - d0 !== 1) begin failures++; $display("FAIL %s rx_done count=%0d expected=1", nm, n_done - d0); end
        checks++; if (n_push - p0 !== int'(xp)) begin failures++; $display("FAIL %s push count=%0d expected=%0d", nm, n_push - p0, xp); end
        checks++; if (n_perr - e0 !== int'(xe)) begin failures++; $display("FAIL %s parity_err count=%0d expected=%0d", nm, n_perr - e0, xe); end
        checks++; if (n_bad - b0 !== int'(xb)) begin failures++; $display("FAIL %s bad_frame count=%0d expected=%0d", nm, n_bad - b0, xb); end
        checks++; if (n_ovf - o0 !== int'(xo)) begin failures++; $display("FAIL %s overflow count=%0d expected=%0d", nm, n_ovf - o0, xo); end
        checks++; if (data_o !== exp_data) begin failures++; $display("FAIL %s data_o=%h expected=%h", nm, data_o, exp_data); end
        if (xp) begin
            checks++; if (last_push !== d) begin failures++; $display("FAIL %s pushed=%h expected=%h", nm, last_push, d); end
        end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL %s busy_after=%b expected=0", nm, busy_o); end
    endtask

    task automatic check_outputs_zero(input string nm);
        checks++;
        if ({data_o, push_o, rx_done_o, parity_err_o, bad_frame_o, overflow_o, busy_o} !== 14'h0) begin
            failures++;
            $display("FAIL %s outputs=%h expected=0", nm,
                     {data_o, push_o, rx_done_o, parity_err_o, bad_frame_o, overflow_o, busy_o});
        end
    endtask

    task automatic test_reset();
        rst = 1; hold(5);
        check_outputs_zero("reset_hold");
        rst = 0; hold(10);
        check_outputs_zero("reset_release");
    endtask

    task automatic test_basic();
        run_frame("a5_8n1", 8'hA5, 0, 0, 0, 0, 0, 0, SPB, 0);
        run_frame("03_even_perr", 8'h03, 1, 0, 0, 1, 0, 0, SPB, 0);
        run_frame("7e_full", 8'h7E, 0, 0, 0, 0, 0, 1, SPB, 0);
        run_frame("c3_odd_2stop", 8'hC3, 1, 1, 1, 0, 0, 0, SPB, 0);
        run_frame("both_err", 8'h81, 1, 0, 0, 1, 1, 0, SPB, 0);
    endtask

    task automatic test_bad_frame();
        int b0, d0, p0;
        b0 = n_bad; d0 = n_done; p0 = n_push;
        parity_en = 0; stop2 = 0;
        drive_bit(1'b0, SPB, 0);
        for (int i = 0; i < 8; i++) drive_bit(i % 2 == 0, SPB, 0);
        rx = 0; hold(3 * SPB);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL break_busy busy=%b expected=1", busy_o); end
        checks++; if (n_bad - b0 !== 1 || n_done - d0 !== 1 || n_push - p0 !== 0) begin
            failures++; $display("FAIL break_strobes bad=%0d done=%0d push=%0d expected=1 1 0", n_bad - b0, n_done - d0, n_push - p0);
        end
        rx = 1; hold(SPB);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL break_exit busy=%b expected=0", busy_o); end
    endtask

    task automatic test_false_start();
        int d0;
        d0 = n_done + n_push + n_bad + n_perr + n_ovf;
        rx = 0; hold(16); rx = 1;
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL false_start_busy busy=%b expected=1", busy_o); end
        hold(40);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL false_start_idle busy=%b expected=0", busy_o); end
        hold(SPB);
        checks++; if (n_done + n_push + n_bad + n_perr + n_ovf - d0 !== 0) begin
            failures++; $display("FAIL false_start_strobes count=%0d expected=0", n_done + n_push + n_bad + n_perr + n_ovf - d0);
        end
    endtask

    task automatic test_rx_en_abort();
        int d0;
        d0 = n_done + n_push + n_bad + n_perr + n_ovf;
        parity_en = 0; stop2 = 0;
        drive_bit(1'b0, SPB, 0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1, SPB, 0);
        rx_en = 0; hold(2);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL abort_busy busy=%b expected=0", busy_o); end
        for (int i = 3; i < 8; i++) drive_bit(i[0], SPB, 0);
        drive_bit(1'b1, SPB, 0);
        rx_en = 1; hold(SPB);
        checks++; if (n_done + n_push + n_bad + n_perr + n_ovf - d0 !== 0) begin
            failures++; $display("FAIL abort_strobes count=%0d expected=0", n_done + n_push + n_bad + n_perr + n_ovf - d0);
        end
    endtask

    task automatic test_async_reset();
        int d0;
        run_frame("pre_reset_3c", 8'h3C, 0, 0, 0, 0, 0, 0, SPB, 0);
        d0 = n_done + n_push + n_bad + n_perr + n_ovf;
        drive_bit(1'b0, SPB, 0);
        drive_bit(1'b1, SPB, 0);
        rx = 0;
        @(posedge clk); #3 rst = 1; #1;
        check_outputs_zero("async_reset_mid");
        hold(8 * SPB);
        rx = 1; hold(SPB);
        rst = 0; hold(SPB);
        exp_data = 0;
        check_outputs_zero("async_reset_after");
        checks++; if (n_done + n_push + n_bad + n_perr + n_ovf - d0 !== 0) begin
            failures++; $display("FAIL async_reset_strobes count=%0d expected=0", n_done + n_push + n_bad + n_perr + n_ovf - d0);
        end
    endtask

    task automatic test_tick_held();
        tick_held = 1;
        hold(4);
        run_frame("held_tick_5a", 8'h5A, 0, 0, 0, 0, 0, 0, OS, 0);
        run_frame("held_tick_rand", 8'($urandom), 1, 1, 1, 0, 0, 0, OS, 0);
        tick_held = 0;
        hold(4);
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            logic [7:0] d;
            bit pen, podd, s2, pinj, sbad, full;
            d = 8'($urandom); pen = 1'($urandom); podd = 1'($urandom); s2 = 1'($urandom);
            pinj = pen && ($urandom % 4 == 0);
            sbad = ($urandom % 5 == 0);
            full = ($urandom % 5 == 0);
            run_frame($sformatf("rand%0d", n), d, pen, podd, s2, pinj, sbad, full, SPB, 0);
        end
    endtask

`ifdef UART_RX_MAJORITY_VOTE_EN
    task automatic test_vote_glitch();
        run_frame("vote_glitch_00", 8'h00, 0, 0, 0, 0, 0, 0, SPB, 1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_bad_frame();
        test_false_start();
        test_rx_en_abort();
        test_tick_held();
        test_random();
`ifdef UART_RX_MAJORITY_VOTE_EN
        test_vote_glitch();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
